// File: rtl/gf180mcu_osu_sc_12t_clkdiv_if.sv
// ----------------------------------------------------------------------------
// gf180mcu_osu_sc_12t_clkdiv_if
// Control/status bundle for the programmable clock divider.
//   EN   : run request (may be asynchronous to CLK)
//   DIV  : ratio select, R = DIV + 2
//   Y    : divided clock (registered)
//   BUSY : divider is running
//   TICK : one-cycle pulse at each Y rise (only with GF180MCU_OSU_SC_CLKDIV_TICK_EN)
// master = ratio/enable source, slave = divider.
// ----------------------------------------------------------------------------
interface gf180mcu_osu_sc_12t_clkdiv_if #(
    parameter int unsigned WIDTH = 4
);
    logic             EN;
    logic [WIDTH-1:0] DIV;
    logic             Y;
    logic             BUSY;
`ifdef GF180MCU_OSU_SC_CLKDIV_TICK_EN
    logic             TICK;

    modport master (output EN, output DIV, input Y, input BUSY, input TICK);
    modport slave  (input EN, input DIV, output Y, output BUSY, output TICK);
`else
    modport master (output EN, output DIV, input Y, input BUSY);
    modport slave  (input EN, input DIV, output Y, output BUSY);
`endif
endinterface

// File: rtl/gf180mcu_osu_sc_12t_clkdiv.sv
// ----------------------------------------------------------------------------
// gf180mcu_osu_sc_12t_clkdiv
// Glitch-free programmable clock divider. Y = CLK / (DIV + 2), high for
// floor(R/2) cycles, low for the rest. Start, stop and ratio changes are
// applied only on output-period boundaries, so Y never emits a runt pulse
// (except on asynchronous reset).
// Ports:
//   CLK : root clock, all flops on posedge
//   RN  : asynchronous active-low reset
//   bus : slave modport carrying EN, DIV, Y, BUSY (and TICK)
// Optional feature macro: GF180MCU_OSU_SC_CLKDIV_TICK_EN adds the TICK flop.
// ----------------------------------------------------------------------------
module gf180mcu_osu_sc_12t_clkdiv #(
    parameter int unsigned WIDTH = 4
) (
    input  logic                         CLK,
    input  logic                         RN,
    gf180mcu_osu_sc_12t_clkdiv_if.slave  bus
);

    // One extra bit so DIV = all-ones plus 2 does not wrap.
    localparam int unsigned CW = WIDTH + 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic            sync1_q;
    logic            en_s;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [CW-1:0]   r_act_q, r_act_d;
    logic [CW-1:0]   h;
    logic [CW-1:0]   cnt_inc;
    logic [CW-1:0]   r_last;
    logic            y_q, y_d;
    logic            busy_q, busy_d;
`ifdef GF180MCU_OSU_SC_CLKDIV_TICK_EN
    logic            tick_q, tick_d;
`endif

    // Two-flop synchronizer for the asynchronous run request.
    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            sync1_q <= 1'b0;
            en_s    <= 1'b0;
        end else begin
            sync1_q <= bus.EN;
            en_s    <= sync1_q;
        end
    end

    assign h       = r_act_q >> 1;
    assign cnt_inc = cnt_q + CW'(1);
    assign r_last  = r_act_q - CW'(1);

    // State and output registers.
    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            r_act_q <= CW'(2);
            y_q     <= 1'b0;
            busy_q  <= 1'b0;
`ifdef GF180MCU_OSU_SC_CLKDIV_TICK_EN
            tick_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            r_act_q <= r_act_d;
            y_q     <= y_d;
            busy_q  <= busy_d;
`ifdef GF180MCU_OSU_SC_CLKDIV_TICK_EN
            tick_q  <= tick_d;
`endif
        end
    end

    // Next-state: the enable and ratio are only looked at on period boundaries.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        r_act_d = r_act_q;
        y_d     = 1'b0;
        busy_d  = 1'b0;
`ifdef GF180MCU_OSU_SC_CLKDIV_TICK_EN
        tick_d  = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (en_s) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    r_act_d = CW'(bus.DIV) + CW'(2);
                    y_d     = 1'b1;
`ifdef GF180MCU_OSU_SC_CLKDIV_TICK_EN
                    tick_d  = 1'b1;
`endif
                end
            end
            RUN: begin
                if (cnt_q != r_last) begin
                    cnt_d = cnt_inc;
                    y_d   = (cnt_inc < h);
                end else if (en_s) begin
                    cnt_d   = '0;
                    r_act_d = CW'(bus.DIV) + CW'(2);
                    y_d     = 1'b1;
`ifdef GF180MCU_OSU_SC_CLKDIV_TICK_EN
                    tick_d  = 1'b1;
`endif
                end else begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        busy_d = (state_d == RUN);
    end

    assign bus.Y    = y_q;
    assign bus.BUSY = busy_q;
`ifdef GF180MCU_OSU_SC_CLKDIV_TICK_EN
    assign bus.TICK = tick_q;
`endif

endmodule
